// File: rtl/param_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// param_counter
//
// Parametrised up/down event/timebase counter. Counts over the range 0..MAX in
// increments of STEP, either wrapping modulo (MAX+1) or clamping at the rails.
// A boundary crossing (or a push against a rail in saturate mode) is an
// "event": it pulses tc for one cycle and sets the sticky ovf flag.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   MAX       top count, 1 <= MAX <= 2**WIDTH-1
//   STEP      amount added/subtracted per enabled cycle, 1 <= STEP <= MAX
//   SATURATE  0 = modulo wrap, 1 = clamp at 0 / MAX
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   en        in   count enable
//   up        in   direction, 1 = up, 0 = down (only looked at when en=1)
//   load      in   synchronous load of load_val (clamped to MAX)
//   load_val  in   load data
//   clr       in   synchronous clear to 0 (highest priority)
//   ovf_clr   in   clears the sticky ovf flag
//   value     out  current count, registered
//   tc        out  one-cycle event pulse, registered
//   ovf       out  sticky event flag, registered
// -----------------------------------------------------------------------------
module param_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX      = 2**WIDTH - 1,
   parameter int unsigned STEP     = 1,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] value,
   output logic             tc,
   output logic             ovf
);

   // All arithmetic that can exceed MAX is done one bit wider than the count
   // so that value+STEP and value+(MAX+1) never lose their carry.
   localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX);
   localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MAX + 1);
   localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

   logic [WIDTH:0]   value_ext;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   dn_sum;
   logic [WIDTH-1:0] up_wrap;
   logic [WIDTH-1:0] dn_wrap;
   logic [WIDTH-1:0] dn_diff;
   logic             up_over;
   logic             dn_under;
   logic             load_clamp;

   logic [WIDTH-1:0] nxt_value;
   logic             nxt_event;

   // Candidate results for both directions are formed in parallel; the
   // selection logic below only picks among them. dn_sum is only meaningful
   // when value < STEP, where value+(MAX+1)-STEP is guaranteed to land in
   // 0..MAX, so truncating it to WIDTH bits is exact.
   assign value_ext  = {1'b0, value};
   assign up_sum     = value_ext + STEP_EXT;
   assign dn_sum     = value_ext + MOD_EXT - STEP_EXT;
   assign up_wrap    = WIDTH'(up_sum - MOD_EXT);
   assign dn_wrap    = WIDTH'(dn_sum);
   assign dn_diff    = value - STEP_W;
   assign up_over    = (up_sum > MAX_EXT);
   assign dn_under   = (value_ext < STEP_EXT);
   assign load_clamp = (load_val > MAX_W);

   // Next-state selection with clr > load > en priority. Only the counting
   // path can raise an event; a clamped load is deliberately not one. In
   // saturate mode a push against a rail keeps reporting an event every
   // cycle because the rail value is re-selected as the "clamped" result.
   always_comb begin
      nxt_value = value;
      nxt_event = 1'b0;
      if (clr) begin
         nxt_value = '0;
      end else if (load) begin
         nxt_value = load_clamp ? MAX_W : load_val;
      end else if (en) begin
         if (up) begin
            if (up_over) begin
               nxt_event = 1'b1;
               nxt_value = SATURATE ? MAX_W : up_wrap;
            end else begin
               nxt_value = up_sum[WIDTH-1:0];
            end
         end else begin
            if (dn_under) begin
               nxt_event = 1'b1;
               nxt_value = SATURATE ? '0 : dn_wrap;
            end else begin
               nxt_value = dn_diff;
            end
         end
      end
   end

   // Output registers. tc is the event of the edge that produced the current
   // value, so it lines up with the post-event count. ovf gives set priority
   // over ovf_clr so an event on the clearing edge is never lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         value <= nxt_value;
         tc    <= nxt_event;
         ovf   <= nxt_event | (ovf & ~ovf_clr);
      end
   end

endmodule

// File: tb/tb_param_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_param_counter
//
// Drives three param_counter instances with the same stimulus:
//   dut0: WIDTH=8 MAX=255 STEP=1 wrap
//   dut1: WIDTH=4 MAX=9   STEP=3 wrap
//   dut2: WIDTH=8 MAX=200 STEP=7 saturate
// Expected responses come from an integer reference model and are queued per
// instance; a separate monitor pops and compares one entry per clock.
// -----------------------------------------------------------------------------
module tb_param_counter;

   typedef struct {
      int v;
      bit t;
      bit o;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       en;
   logic       up;
   logic       load;
   logic [7:0] load_val;
   logic       clr;
   logic       ovf_clr;

   logic [7:0] val0;
   logic [3:0] val1;
   logic [7:0] val2;
   logic       tc0, tc1, tc2;
   logic       ovf0, ovf1, ovf2;

   int checks   = 0;
   int failures = 0;

   // reference model state and per-instance configuration
   int maxv  [3] = '{255, 9, 200};
   int stepv [3] = '{1, 3, 7};
   bit satv  [3] = '{1'b0, 1'b0, 1'b1};
   int maskv [3] = '{255, 15, 255};
   int mv    [3];
   bit mt    [3];
   bit mo    [3];

   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];

   param_counter #(.WIDTH(8), .MAX(255), .STEP(1), .SATURATE(1'b0)) dut0 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val), .clr(clr), .ovf_clr(ovf_clr),
      .value(val0), .tc(tc0), .ovf(ovf0)
   );

   param_counter #(.WIDTH(4), .MAX(9), .STEP(3), .SATURATE(1'b0)) dut1 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val[3:0]), .clr(clr), .ovf_clr(ovf_clr),
      .value(val1), .tc(tc1), .ovf(ovf1)
   );

   param_counter #(.WIDTH(8), .MAX(200), .STEP(7), .SATURATE(1'b1)) dut2 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val), .clr(clr), .ovf_clr(ovf_clr),
      .value(val2), .tc(tc2), .ovf(ovf2)
   );

   // free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single comparison point; every check in the bench goes through here
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dutValue(input int i);
      case (i)
         0: return int'(val0);
         1: return int'(val1);
         default: return int'(val2);
      endcase
   endfunction

   function automatic int dutTc(input int i);
      case (i)
         0: return int'(tc0);
         1: return int'(tc1);
         default: return int'(tc2);
      endcase
   endfunction

   function automatic int dutOvf(input int i);
      case (i)
         0: return int'(ovf0);
         1: return int'(ovf1);
         default: return int'(ovf2);
      endcase
   endfunction

   task automatic compareDut(input int i, input exp_t e);
      checkOutput($sformatf("dut%0d.value", i), dutValue(i), e.v);
      checkOutput($sformatf("dut%0d.tc", i), dutTc(i), int'(e.t));
      checkOutput($sformatf("dut%0d.ovf", i), dutOvf(i), int'(e.o));
   endtask

   // Reference model: integer arithmetic straight from the counting rules,
   // using modulo (MAX+1) for wrap and explicit rails for saturate.
   task automatic modelEdge(input bit e, input bit u, input bit l, input int lv,
                            input bit c, input bit oc);
      exp_t x;
      for (int i = 0; i < 3; i++) begin
         int raw;
         int ldv;
         bit ev;
         ev = 1'b0;
         if (c) begin
            mv[i] = 0;
         end else if (l) begin
            ldv   = lv & maskv[i];
            mv[i] = (ldv > maxv[i]) ? maxv[i] : ldv;
         end else if (e) begin
            raw = u ? mv[i] + stepv[i] : mv[i] - stepv[i];
            if (raw > maxv[i]) begin
               ev    = 1'b1;
               mv[i] = satv[i] ? maxv[i] : raw % (maxv[i] + 1);
            end else if (raw < 0) begin
               ev    = 1'b1;
               mv[i] = satv[i] ? 0 : raw + (maxv[i] + 1);
            end else begin
               mv[i] = raw;
            end
         end
         mt[i] = ev;
         mo[i] = ev | (mo[i] & !oc);
      end
      x.v = mv[0]; x.t = mt[0]; x.o = mo[0]; q0.push_back(x);
      x.v = mv[1]; x.t = mt[1]; x.o = mo[1]; q1.push_back(x);
      x.v = mv[2]; x.t = mt[2]; x.o = mo[2]; q2.push_back(x);
   endtask

   // Drives one cycle of inputs just after a rising edge; they are sampled
   // by the following edge, whose expected result is queued now.
   task automatic applyStimulus(input bit e, input bit u, input bit l, input int lv,
                                input bit c, input bit oc);
      @(posedge clk);
      #2;
      en       = e;
      up       = u;
      load     = l;
      load_val = 8'(lv);
      clr      = c;
      ovf_clr  = oc;
      modelEdge(e, u, l, lv, c, oc);
   endtask

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         mv[i] = 0;
         mt[i] = 1'b0;
         mo[i] = 1'b0;
      end
   endtask

   // Monitor: the counter presents a fresh result after every edge, so one
   // queued expectation per instance is consumed per clock when available.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin e = q0.pop_front(); compareDut(0, e); end
         if (q1.size() > 0) begin e = q1.pop_front(); compareDut(1, e); end
         if (q2.size() > 0) begin e = q2.pop_front(); compareDut(2, e); end
      end
   end

   // Watchdog: the stimulus is finite, so this only fires on a broken run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset    = 1'b0;
      en       = 1'b0;
      up       = 1'b0;
      load     = 1'b0;
      load_val = 8'h00;
      clr      = 1'b0;
      ovf_clr  = 1'b0;
      modelReset();

      // reset state
      #12;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("reset dut%0d.value", i), dutValue(i), 0);
         checkOutput($sformatf("reset dut%0d.tc", i), dutTc(i), 0);
         checkOutput($sformatf("reset dut%0d.ovf", i), dutOvf(i), 0);
      end
      @(negedge clk);
      reset = 1'b1;

      // default wrap: FE -> FF, 00 (event), 01
      applyStimulus(0, 0, 1, 8'hFE, 0, 0);
      repeat (3) applyStimulus(1, 1, 0, 0, 0, 0);

      // async reset mid-cycle with value=0x37 and ovf set
      applyStimulus(0, 0, 1, 8'h37, 0, 0);
      @(posedge clk);
      #3;
      checkOutput("pre-reset dut0.value", int'(val0), 8'h37);
      checkOutput("pre-reset dut0.ovf", int'(ovf0), 1);
      reset = 1'b0;
      load  = 1'b0;
      en    = 1'b1;
      up    = 1'b1;
      #1;
      modelReset();
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("async reset dut%0d.value", i), dutValue(i), 0);
         checkOutput($sformatf("async reset dut%0d.tc", i), dutTc(i), 0);
         checkOutput($sformatf("async reset dut%0d.ovf", i), dutOvf(i), 0);
      end
      // reset held across an enabled edge must keep everything at zero
      @(posedge clk);
      #1;
      checkOutput("reset held dut0.value", int'(val0), 0);
      en = 1'b0;
      up = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // modulus/step: up 3,6,9,2 then down 9,6 (dut1)
      applyStimulus(0, 0, 0, 0, 1, 0);
      repeat (4) applyStimulus(1, 1, 0, 0, 0, 0);
      repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);

      // saturate: load 198 then up x3, load 5 then down (dut2)
      applyStimulus(0, 0, 1, 198, 0, 0);
      repeat (3) applyStimulus(1, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 5, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);

      // priority and load clamp
      applyStimulus(1, 1, 1, 250, 1, 0);
      applyStimulus(1, 1, 1, 250, 0, 0);

      // ovf handling: clear with event, clear alone, clr leaves ovf
      applyStimulus(0, 0, 1, 8'hFF, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 8'hFF, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         applyStimulus(($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 255)),
                       ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 7) == 0));
      end
      applyStimulus(0, 0, 0, 0, 0, 0);

      // drain the scoreboard, bounded by a few cycles
      repeat (3) @(posedge clk);
      #3;
      checkOutput("scoreboard drained", q0.size() + q1.size() + q2.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
